rand_rotation_buffer: RTL and testbench
=======================================

// Module: rand_rotation_buffer
// PURPOSE
//   Holds one block of fresh mask randomness and hands out NUM_TAPS rotated views of it to a masked round pipeline.
//   On each advance the stored word is rotated right by STEP. After MAX_USES advances the block asks for a new word.
//   Sits between the PRNG/randomness port and the masked S-box layers; it reduces fresh randomness per round.
// PARAMETERS
//   WIDTH     144  bits per randomness word
//   STEP      9    rotate-right amount per tap and per advance; 0 < STEP < WIDTH
//   NUM_TAPS  8    rotated views exported; tap k = state rotated right by k*STEP (tap 0 = state)
//   MAX_USES  16   advances allowed per loaded word; >= 1
// PORTS
//   clk           in   1                 clock, rising edge
//   rst_n         in   1                 asynchronous active-low reset
//   rnd_in        in   WIDTH             fresh randomness word
//   rnd_in_valid  in   1                 rnd_in valid
//   rnd_in_ready  out  1                 block accepts rnd_in this cycle
//   adv           in   1                 consumer used current taps; rotate for next round
//   taps_out      out  NUM_TAPS*WIDTH    tap k at [k*WIDTH +: WIDTH]
//   taps_valid    out  1                 taps_out carries an unexhausted word
//   use_cnt       out  $clog2(MAX_USES+1) advances done on current word
//   err_underrun  out  1                 sticky: adv seen while taps_valid = 0
// BEHAVIOUR
//   Reset: state EMPTY, word reg = 0, use_cnt = 0, taps_out = 0, taps_valid = 0, rnd_in_ready = 1, err_underrun = 0.
//   States:
//     EMPTY  -> ACTIVE  on rnd_in_valid & rnd_in_ready; loads word, use_cnt = 0.
//     ACTIVE -> ACTIVE  on adv with use_cnt < MAX_USES-1; word = {word[STEP-1:0], word[WIDTH-1:STEP]}, use_cnt += 1.
//     ACTIVE -> EXHAUST on adv with use_cnt == MAX_USES-1; rotates, use_cnt = MAX_USES.
//     EXHAUST -> ACTIVE on a load, same as from EMPTY.
//   rnd_in_ready = (state != ACTIVE). No load is accepted in ACTIVE; rnd_in is ignored there.
//   taps_valid = (state == ACTIVE). Taps are combinational from the word reg, so latency is 0 cycles from the reg update.
//   Load and adv in the same cycle in EMPTY/EXHAUST: the load wins, the word is not rotated, and err_underrun is set.
//   adv in EMPTY/EXHAUST: no rotation, no count change, err_underrun set; it clears only on reset.
//   MAX_USES = 1: the first adv goes straight to EXHAUST.
//   rst_n asserted mid-operation: everything returns to reset values at once; the word is discarded.
//   EXHAUST keeps the last rotated word in the reg; taps_out still shows it, but taps_valid = 0.
// CONFIGURATION
//   RAND_ROT_OUTREG_EN defined:
//     - taps_out and taps_valid are registered, with reset value 0, and lag the word reg by 1 cycle.
//     - This gives glitch-free randomness into masked gadgets.
//     - rnd_in_ready stays unregistered.
//   RAND_ROT_OUTREG_EN undefined: taps_out and taps_valid are combinational as described above.
// STRUCTURE
//   Package rand_rot_pkg:
//     - state enum {EMPTY, ACTIVE, EXHAUST}
//     - function rotr(word, amt) parametrised on WIDTH
//     - localparam CNT_W = $clog2(MAX_USES+1)
//   Sub-module rand_rot_taps: purely combinational. Maps WIDTH word -> NUM_TAPS rotated views using STEP.
//   This top holds the FSM, counter, word reg and optional output reg.
// TESTING
//   Reset then load rnd_in = 144'h1 -> tap0 bit0 = 1, tap1 bit135 = 1, tap7 bit81 = 1, taps_valid = 1, use_cnt = 0.
//   After that load, one adv -> tap0 bit135 = 1, use_cnt = 1; rnd_in_ready stays 0.
//   MAX_USES = 4, 4 advs -> taps_valid = 0 after the 4th, rnd_in_ready = 1, use_cnt = 4; a 5th adv sets err_underrun.
//   In EXHAUST, load 144'hFF together with adv -> ACTIVE, tap0 = 144'hFF unrotated, use_cnt = 0, err_underrun = 1.
//   rst_n low mid-ACTIVE (use_cnt = 2) -> taps_out = 0, taps_valid = 0, use_cnt = 0, rnd_in_ready = 1 asynchronously.
//   With RAND_ROT_OUTREG_EN -> repeat test 1; taps_valid and taps_out appear exactly 1 cycle after the load edge.

Source files
------------

// File: rtl/rand_rot_pkg.sv
// Shared types, defaults and the rotate helper for the mask-randomness rotation buffer.
package rand_rot_pkg;

  localparam int unsigned WIDTH        = 144;
  localparam int unsigned STEP         = 9;
  localparam int unsigned NUM_TAPS     = 8;
  localparam int unsigned MAX_USES_DEF = 16;
  localparam int unsigned CNT_W        = $clog2(MAX_USES_DEF + 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ACTIVE  = 2'd1,
    EXHAUST = 2'd2
  } state_e;

  typedef logic [WIDTH-1:0]                word_t;
  typedef logic [NUM_TAPS-1:0][WIDTH-1:0]  taps_t;

  // Rotate right by amt (taken modulo WIDTH).
  function automatic word_t rotr(word_t w, int unsigned amt);
    int unsigned a;
    a = amt % WIDTH;
    if (a == 0) return w;
    return (w >> a) | (w << (WIDTH - a));
  endfunction

endpackage

// File: rtl/rand_rotation_buffer_if.sv
// Randomness-in / rotated-taps-out bus of the rotation buffer.
interface rand_rotation_buffer_if
  import rand_rot_pkg::*;
#(
  parameter int unsigned MAX_USES = MAX_USES_DEF
);
  localparam int unsigned CW = $clog2(MAX_USES + 1);

  word_t           rnd_in;
  logic            rnd_in_valid;
  logic            rnd_in_ready;
  logic            adv;
  taps_t           taps_out;
  logic            taps_valid;
  logic [CW-1:0]   use_cnt;
  logic            err_underrun;

  // Randomness source plus round pipeline side.
  modport master (
    output rnd_in, rnd_in_valid, adv,
    input  rnd_in_ready, taps_out, taps_valid, use_cnt, err_underrun
  );

  // Rotation buffer side.
  modport slave (
    input  rnd_in, rnd_in_valid, adv,
    output rnd_in_ready, taps_out, taps_valid, use_cnt, err_underrun
  );
endinterface

// File: rtl/rand_rot_taps.sv
// Combinational fan-out of one word into NUM_TAPS views, tap k rotated right by k*STEP.
module rand_rot_taps
  import rand_rot_pkg::*;
(
  input  word_t word,
  output taps_t taps
);

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    assign taps[k] = rotr(word, STEP * k);
  end

endmodule

// File: rtl/rand_rotation_buffer.sv
// Holds one fresh randomness word and exports rotated views of it, re-rotating on each advance.
// Optional RAND_ROT_OUTREG_EN registers taps_out/taps_valid for glitch-free gadget inputs.
module rand_rotation_buffer
  import rand_rot_pkg::*;
#(
  parameter int unsigned MAX_USES = MAX_USES_DEF
)(
  input  logic                   clk,
  input  logic                   rst_n,
  rand_rotation_buffer_if.slave  bus
);

  localparam int unsigned CW = $clog2(MAX_USES + 1);

  if (MAX_USES < 1) begin : g_bad_max_uses
    $error("rand_rotation_buffer: MAX_USES must be at least 1");
  end
  if (STEP == 0 || STEP >= WIDTH) begin : g_bad_step
    $error("rand_rotation_buffer: STEP must lie in 1..WIDTH-1");
  end

  state_e          state_q;
  state_e          state_d;
  word_t           word_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q;

  logic            ready_c;
  logic            load_c;
  logic            rotate_c;
  logic            underrun_c;
  logic            last_use_c;
  logic            taps_valid_c;
  taps_t           taps_c;

  assign last_use_c = (cnt_q == CW'(MAX_USES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic; a load always wins over an advance outside ACTIVE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY,
      EXHAUST: if (load_c) state_d = ACTIVE;
      ACTIVE:  if (bus.adv && last_use_c) state_d = EXHAUST;
      default: state_d = EMPTY;
    endcase
  end

  // Decoded controls from the current state.
  always_comb begin
    ready_c      = 1'b0;
    taps_valid_c = 1'b0;
    load_c       = 1'b0;
    rotate_c     = 1'b0;
    underrun_c   = 1'b0;
    unique case (state_q)
      ACTIVE: begin
        taps_valid_c = 1'b1;
        rotate_c     = bus.adv;
      end
      EMPTY,
      EXHAUST: begin
        ready_c    = 1'b1;
        load_c     = bus.rnd_in_valid;
        underrun_c = bus.adv;
      end
      default: ready_c = 1'b0;
    endcase
  end

  // Word register and use counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (load_c) begin
      word_q <= bus.rnd_in;
      cnt_q  <= '0;
    end else if (rotate_c) begin
      word_q <= rotr(word_q, STEP);
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  // Sticky underrun flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          err_q <= 1'b0;
    else if (underrun_c) err_q <= 1'b1;
  end

  rand_rot_taps u_taps (
    .word (word_q),
    .taps (taps_c)
  );

  assign bus.rnd_in_ready = ready_c;
  assign bus.use_cnt      = cnt_q;
  assign bus.err_underrun = err_q;

`ifdef RAND_ROT_OUTREG_EN
  taps_t taps_q;
  logic  taps_valid_q;

  // Output stage: taps lag the word register by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q       <= '0;
      taps_valid_q <= 1'b0;
    end else begin
      taps_q       <= taps_c;
      taps_valid_q <= taps_valid_c;
    end
  end

  assign bus.taps_out   = taps_q;
  assign bus.taps_valid = taps_valid_q;
`else
  assign bus.taps_out   = taps_c;
  assign bus.taps_valid = taps_valid_c;
`endif

endmodule

// File: tb/tb_rand_rotation_buffer.sv
// Self-checking bench: three buffers (MAX_USES 16, 4, 1) share one stimulus stream and a reference model.
module tb_rand_rotation_buffer;
  import rand_rot_pkg::*;

`ifdef RAND_ROT_OUTREG_EN
  localparam bit OUTREG = 1'b1;
`else
  localparam bit OUTREG = 1'b0;
`endif
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [143:0] drv_rnd = '0;
  logic         drv_vld = 1'b0;
  logic         drv_adv = 1'b0;

  rand_rotation_buffer_if #(.MAX_USES(16)) if_a ();
  rand_rotation_buffer_if #(.MAX_USES(4))  if_b ();
  rand_rotation_buffer_if #(.MAX_USES(1))  if_c ();

  rand_rotation_buffer #(.MAX_USES(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  rand_rotation_buffer #(.MAX_USES(4))  u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  rand_rotation_buffer #(.MAX_USES(1))  u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  assign if_a.rnd_in = drv_rnd;  assign if_a.rnd_in_valid = drv_vld;  assign if_a.adv = drv_adv;
  assign if_b.rnd_in = drv_rnd;  assign if_b.rnd_in_valid = drv_vld;  assign if_b.adv = drv_adv;
  assign if_c.rnd_in = drv_rnd;  assign if_c.rnd_in_valid = drv_vld;  assign if_c.adv = drv_adv;

  taps_t obs_taps  [NDUT];
  logic  obs_valid [NDUT];
  logic  obs_ready [NDUT];
  logic  obs_err   [NDUT];
  int    obs_cnt   [NDUT];

  assign obs_taps[0] = if_a.taps_out;  assign obs_valid[0] = if_a.taps_valid;
  assign obs_taps[1] = if_b.taps_out;  assign obs_valid[1] = if_b.taps_valid;
  assign obs_taps[2] = if_c.taps_out;  assign obs_valid[2] = if_c.taps_valid;
  assign obs_ready[0] = if_a.rnd_in_ready;  assign obs_err[0] = if_a.err_underrun;
  assign obs_ready[1] = if_b.rnd_in_ready;  assign obs_err[1] = if_b.err_underrun;
  assign obs_ready[2] = if_c.rnd_in_ready;  assign obs_err[2] = if_c.err_underrun;
  assign obs_cnt[0] = 32'(if_a.use_cnt);
  assign obs_cnt[1] = 32'(if_b.use_cnt);
  assign obs_cnt[2] = 32'(if_c.use_cnt);

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the held word, uses so far, whether it is still usable, sticky error.
  int           max_uses [NDUT] = '{16, 4, 1};
  logic [143:0] m_word   [NDUT];
  int           m_uses   [NDUT];
  bit           m_valid  [NDUT];
  bit           m_err    [NDUT];
  logic [143:0] p_word   [NDUT];
  bit           p_valid  [NDUT];

  function automatic logic [143:0] rot_right(logic [143:0] w, int r);
    logic [287:0] dbl;
    dbl = {w, w} >> (r % 144);
    return dbl[143:0];
  endfunction

  function automatic logic [143:0] exp_tap(int d, int k);
    return rot_right(OUTREG ? p_word[d] : m_word[d], k * 9);
  endfunction

  function automatic bit exp_valid(int d);
    return OUTREG ? p_valid[d] : m_valid[d];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_word[d] = '0; m_uses[d] = 0; m_valid[d] = 0; m_err[d] = 0;
      p_word[d] = '0; p_valid[d] = 0;
    end
  endtask

  // Advance model and DUTs by one clock with the currently driven inputs.
  task automatic tick();
    for (int d = 0; d < NDUT; d++) begin
      p_word[d]  = m_word[d];
      p_valid[d] = m_valid[d];
      if (drv_adv && !m_valid[d]) m_err[d] = 1;
      if (!m_valid[d] && drv_vld) begin
        m_word[d] = drv_rnd; m_uses[d] = 0; m_valid[d] = 1;
      end else if (m_valid[d] && drv_adv) begin
        m_word[d] = rot_right(m_word[d], 9);
        m_uses[d]++;
        if (m_uses[d] == max_uses[d]) m_valid[d] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drv_vld = 1'b0; drv_adv = 1'b0;
  endtask

  // With the output register, let the taps catch up with the word register.
  task automatic settle();
    idle();
    if (OUTREG) tick();
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < NDUT; d++) begin
      n_tests++;
      if (obs_taps[d] !== '0 || obs_valid[d] !== 1'b0 || obs_ready[d] !== 1'b1 ||
          obs_cnt[d] !== 0 || obs_err[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset dut%0d: valid=%b ready=%b cnt=%0d err=%b taps_zero=%b, required 0/1/0/0/1",
                 d, obs_valid[d], obs_ready[d], obs_cnt[d], obs_err[d], obs_taps[d] === '0);
      end
    end
  endtask

  task automatic test_load();
    drv_rnd = 144'h1; drv_vld = 1'b1; drv_adv = 1'b0;
    tick();
    idle();
    if (OUTREG) begin
      n_tests++;
      if (obs_valid[0] !== 1'b0 || obs_taps[0] !== '0) begin
        n_fail++;
        $display("FAIL load_lag: valid=%b taps_zero=%b, required 0/1", obs_valid[0], obs_taps[0] === '0);
      end
    end
    settle();
    n_tests++;
    if (obs_taps[0][0][0] !== 1'b1 || obs_taps[0][1][135] !== 1'b1 || obs_taps[0][7][81] !== 1'b1) begin
      n_fail++;
      $display("FAIL load_taps: tap0b0=%b tap1b135=%b tap7b81=%b, required 1/1/1",
               obs_taps[0][0][0], obs_taps[0][1][135], obs_taps[0][7][81]);
    end
    n_tests++;
    if (obs_valid[0] !== 1'b1 || obs_cnt[0] !== 0 || obs_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL load_ctrl: valid=%b cnt=%0d ready=%b, required 1/0/0", obs_valid[0], obs_cnt[0], obs_ready[0]);
    end
  endtask

  task automatic test_adv();
    drv_adv = 1'b1;
    tick();
    settle();
    n_tests++;
    if (obs_taps[0][0] !== 144'(1) << 135 || obs_cnt[0] !== 1 || obs_ready[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL adv1: tap0=%h cnt=%0d ready=%b, required bit135 only/1/0", obs_taps[0][0], obs_cnt[0], obs_ready[0]);
    end
    n_tests++;
    if (obs_valid[2] !== 1'b0 || obs_ready[2] !== 1'b1 || obs_cnt[2] !== 1) begin
      n_fail++;
      $display("FAIL max1_exhaust: valid=%b ready=%b cnt=%0d, required 0/1/1", obs_valid[2], obs_ready[2], obs_cnt[2]);
    end
    // A load offered while ACTIVE must be ignored.
    drv_rnd = 144'hDEAD_BEEF; drv_vld = 1'b1;
    tick();
    settle();
    n_tests++;
    if (obs_taps[0][0] !== 144'(1) << 135 || obs_cnt[0] !== 1) begin
      n_fail++;
      $display("FAIL active_ignores_load: tap0=%h cnt=%0d, required bit135 only/1", obs_taps[0][0], obs_cnt[0]);
    end
  endtask

  task automatic test_exhaust();
    for (int i = 2; i <= 4; i++) begin
      drv_adv = 1'b1;
      tick();
      settle();
      n_tests++;
      if (obs_cnt[1] !== i || obs_valid[1] !== (i < 4) || obs_ready[1] !== (i == 4) || obs_err[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL exhaust_adv%0d: cnt=%0d valid=%b ready=%b err=%b, required %0d/%b/%b/0",
                 i, obs_cnt[1], obs_valid[1], obs_ready[1], obs_err[1], i, i < 4, i == 4);
      end
    end
    drv_adv = 1'b1;
    tick();
    settle();
    n_tests++;
    if (obs_err[1] !== 1'b1 || obs_cnt[1] !== 4 || obs_taps[1][0] !== rot_right(144'h1, 36)) begin
      n_fail++;
      $display("FAIL underrun: err=%b cnt=%0d tap0=%h, required 1/4/%h",
               obs_err[1], obs_cnt[1], obs_taps[1][0], rot_right(144'h1, 36));
    end
    n_tests++;
    if (obs_err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL no_spurious_err: err=%b, required 0", obs_err[0]);
    end
  endtask

  task automatic test_load_adv();
    drv_rnd = 144'hFF; drv_vld = 1'b1; drv_adv = 1'b1;
    tick();
    settle();
    n_tests++;
    if (obs_taps[1][0] !== 144'hFF || obs_cnt[1] !== 0 || obs_err[1] !== 1'b1 || obs_valid[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL load_with_adv: tap0=%h cnt=%0d err=%b valid=%b, required ff/0/1/1",
               obs_taps[1][0], obs_cnt[1], obs_err[1], obs_valid[1]);
    end
  endtask

  task automatic test_async_reset();
    logic [143:0] w;
    do_reset();
    w = 144'({$urandom, $urandom, $urandom, $urandom, $urandom}) | 144'h1;
    drv_rnd = w; drv_vld = 1'b1;
    tick();
    idle();
    drv_adv = 1'b1;
    tick();
    tick();
    idle();
    n_tests++;
    if (obs_cnt[0] !== 2) begin
      n_fail++;
      $display("FAIL pre_reset_cnt: cnt=%0d, required 2", obs_cnt[0]);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs_taps[0] !== '0 || obs_valid[0] !== 1'b0 || obs_cnt[0] !== 0 || obs_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: taps_zero=%b valid=%b cnt=%0d ready=%b, required 1/0/0/1",
               obs_taps[0] === '0, obs_valid[0], obs_cnt[0], obs_ready[0]);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      drv_rnd = 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
      drv_vld = ($urandom_range(0, 9) < 3);
      drv_adv = ($urandom_range(0, 9) < 6);
      tick();
      for (int d = 0; d < NDUT; d++) begin
        n_tests++;
        if (obs_valid[d] !== exp_valid(d) || obs_ready[d] !== !m_valid[d] ||
            obs_cnt[d] !== m_uses[d] || obs_err[d] !== m_err[d]) begin
          n_fail++;
          $display("FAIL rand_ctrl c%0d dut%0d: valid=%b ready=%b cnt=%0d err=%b, required %b/%b/%0d/%b",
                   cyc, d, obs_valid[d], obs_ready[d], obs_cnt[d], obs_err[d],
                   exp_valid(d), !m_valid[d], m_uses[d], m_err[d]);
        end
        for (int k = 0; k < 8; k++) begin
          n_tests++;
          if (obs_taps[d][k] !== exp_tap(d, k)) begin
            n_fail++;
            $display("FAIL rand_tap c%0d dut%0d tap%0d: got %h required %h",
                     cyc, d, k, obs_taps[d][k], exp_tap(d, k));
          end
        end
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_adv();
    test_exhaust();
    test_load_adv();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
